result_bus_arbiter: RTL and testbench

Shares the ROB's two result-write ports (ALU1/ALU2-style buses) among NUM_REQ completing units: ALU0, ALU1, LSB load, and branch/JALR unit.
- Picks up to two pending results per cycle with rotating round-robin priority.
- Registers the picks onto two common result buses that drive both the ROB and the reservation stations.
- Drops everything in flight on a misprediction flush from the ROB.

---
 rtl/result_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_result_bus_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_bus_arbiter.sv
// Result-bus arbiter: shares the two ROB/RS result-write buses among NUM_REQ
// completing units using rotating round-robin priority. Up to two results are
// accepted per cycle and appear on the buses one cycle later.
module result_bus_arbiter #(
    parameter int ROB_WIDTH = 4,
    parameter int NUM_REQ   = 4,
    parameter int REQ_WIDTH = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          flush_in,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*32-1:0]         req_value,
    input  logic [NUM_REQ*ROB_WIDTH-1:0]  req_tag,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic                          bus0_valid,
    output logic [31:0]                   bus0_value,
    output logic [ROB_WIDTH-1:0]          bus0_tag,
    output logic [REQ_WIDTH-1:0]          bus0_src,
    output logic                          bus1_valid,
    output logic [31:0]                   bus1_value,
    output logic [ROB_WIDTH-1:0]          bus1_tag,
    output logic [REQ_WIDTH-1:0]          bus1_src,
    output logic [15:0]                   conflict_cnt
);

    // Index arithmetic wraps at NUM_REQ, which need not be a power of two.
    function automatic logic [REQ_WIDTH-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return REQ_WIDTH'(s);
    endfunction

    // Saturating increment so the counter sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic                 grant_en;
    logic [REQ_WIDTH-1:0] rr_ptr;
    logic                 pick0_vld_p0;
    logic                 pick1_vld_p0;
    logic [REQ_WIDTH-1:0] pick0_p0;
    logic [REQ_WIDTH-1:0] pick1_p0;
    logic [31:0]          pick0_value_p0;
    logic [31:0]          pick1_value_p0;
    logic [ROB_WIDTH-1:0] pick0_tag_p0;
    logic [ROB_WIDTH-1:0] pick1_tag_p0;
    logic                 conflict_p0;
    logic [REQ_WIDTH-1:0] rr_next_p0;

    // Grants are suppressed during reset, pause and flush.
    assign grant_en = rst_in & rdy_in & ~flush_in;

    // Scan from rr_ptr upward; the first two valid requesters become pick0/pick1.
    always_comb begin
        logic [REQ_WIDTH-1:0] idx;
        idx          = '0;
        pick0_vld_p0 = 1'b0;
        pick1_vld_p0 = 1'b0;
        pick0_p0     = '0;
        pick1_p0     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = wrap_idx(int'(rr_ptr), k);
            if (req_valid[idx]) begin
                if (!pick0_vld_p0) begin
                    pick0_vld_p0 = 1'b1;
                    pick0_p0     = idx;
                end else if (!pick1_vld_p0) begin
                    pick1_vld_p0 = 1'b1;
                    pick1_p0     = idx;
                end
            end
        end
    end

    assign pick0_value_p0 = req_value[32*int'(pick0_p0) +: 32];
    assign pick1_value_p0 = req_value[32*int'(pick1_p0) +: 32];
    assign pick0_tag_p0   = req_tag[ROB_WIDTH*int'(pick0_p0) +: ROB_WIDTH];
    assign pick1_tag_p0   = req_tag[ROB_WIDTH*int'(pick1_p0) +: ROB_WIDTH];
    assign conflict_p0    = ($countones(req_valid) > 2);

    // Pointer moves just past the last requester granted this cycle.
    assign rr_next_p0 = pick1_vld_p0 ? wrap_idx(int'(pick1_p0), 1) :
                        pick0_vld_p0 ? wrap_idx(int'(pick0_p0), 1) : rr_ptr;

    // Combinational grant mask returned to the units for their handshake.
    always_comb begin
        req_grant = '0;
        if (grant_en) begin
            if (pick0_vld_p0) req_grant[pick0_p0] = 1'b1;
            if (pick1_vld_p0) req_grant[pick1_p0] = 1'b1;
        end
    end

    // ---- stage p0 -> p1: register picks onto the result buses ----
    // Bus, pointer and conflict-counter state; holds while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bus0_valid   <= 1'b0;
            bus0_value   <= '0;
            bus0_tag     <= '0;
            bus0_src     <= '0;
            bus1_valid   <= 1'b0;
            bus1_value   <= '0;
            bus1_tag     <= '0;
            bus1_src     <= '0;
            rr_ptr       <= '0;
            conflict_cnt <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                bus0_valid <= 1'b0;
                bus1_valid <= 1'b0;
                rr_ptr     <= '0;
            end else begin
                bus0_valid <= pick0_vld_p0;
                bus1_valid <= pick1_vld_p0;
                if (pick0_vld_p0) begin
                    bus0_value <= pick0_value_p0;
                    bus0_tag   <= pick0_tag_p0;
                    bus0_src   <= pick0_p0;
                end
                if (pick1_vld_p0) begin
                    bus1_value <= pick1_value_p0;
                    bus1_tag   <= pick1_tag_p0;
                    bus1_src   <= pick1_p0;
                end
                rr_ptr <= rr_next_p0;
                if (conflict_p0) conflict_cnt <= sat_inc16(conflict_cnt);
            end
        end
    end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Testbench for result_bus_arbiter: directed scenarios plus randomized traffic
// compared against a distance-based round-robin reference model.
module tb_result_bus_arbiter;

    localparam int N  = 4;
    localparam int TW = 4;

    logic            clk_in;
    logic            rst_in;
    logic            rdy_in;
    logic            flush_in;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_value;
    logic [N*TW-1:0] req_tag;
    logic [N-1:0]    req_grant;
    logic            bus0_valid, bus1_valid;
    logic [31:0]     bus0_value, bus1_value;
    logic [TW-1:0]   bus0_tag, bus1_tag;
    logic [1:0]      bus0_src, bus1_src;
    logic [15:0]     conflict_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    int          m_rr;
    logic        m_b0v, m_b1v;
    logic [31:0] m_b0val, m_b1val;
    logic [3:0]  m_b0tag, m_b1tag;
    logic [1:0]  m_b0src, m_b1src;
    logic [15:0] m_cnt;

    result_bus_arbiter #(.ROB_WIDTH(TW), .NUM_REQ(N), .REQ_WIDTH(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .req_valid(req_valid), .req_value(req_value), .req_tag(req_tag),
        .req_grant(req_grant),
        .bus0_valid(bus0_valid), .bus0_value(bus0_value), .bus0_tag(bus0_tag), .bus0_src(bus0_src),
        .bus1_valid(bus1_valid), .bus1_value(bus1_value), .bus1_tag(bus1_tag), .bus1_src(bus1_src),
        .conflict_cnt(conflict_cnt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic void model_zero();
        m_rr = 0; m_b0v = 0; m_b1v = 0; m_b0val = 0; m_b1val = 0;
        m_b0tag = 0; m_b1tag = 0; m_b0src = 0; m_b1src = 0; m_cnt = 0;
    endfunction

    // Two valid units with the smallest rotated distance from the pointer win.
    function automatic void model_picks(output int p0, output int p1);
        int d0, d1, d;
        p0 = -1; p1 = -1; d0 = N; d1 = N;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i]) begin
                d = (i - m_rr + N) % N;
                if (d < d0) begin
                    p1 = p0; d1 = d0; p0 = i; d0 = d;
                end else if (d < d1) begin
                    p1 = i; d1 = d;
                end
            end
        end
    endfunction

    function automatic logic [3:0] exp_grant();
        int p0, p1;
        logic [3:0] g;
        g = 4'b0;
        if (rst_in && rdy_in && !flush_in) begin
            model_picks(p0, p1);
            if (p0 >= 0) g[p0] = 1'b1;
            if (p1 >= 0) g[p1] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [38:0] bus_vec(input logic v, input logic [3:0] t,
                                            input logic [1:0] s, input logic [31:0] d);
        return v ? {1'b1, t, s, d} : 39'd0;
    endfunction

    // Advance one clock and apply the specified edge behaviour to the model.
    task automatic tick();
        int p0, p1;
        logic up;
        logic [31:0] v0, v1;
        logic [3:0] t0, t1;
        model_picks(p0, p1);
        up = ($countones(req_valid) > 2);
        v0 = (p0 >= 0) ? req_value[32*p0 +: 32] : 32'd0;
        v1 = (p1 >= 0) ? req_value[32*p1 +: 32] : 32'd0;
        t0 = (p0 >= 0) ? req_tag[TW*p0 +: TW] : 4'd0;
        t1 = (p1 >= 0) ? req_tag[TW*p1 +: TW] : 4'd0;
        @(posedge clk_in);
        #1;
        if (!rst_in) model_zero();
        else if (rdy_in) begin
            if (flush_in) begin
                m_b0v = 0; m_b1v = 0; m_rr = 0;
            end else begin
                m_b0v = (p0 >= 0);
                m_b1v = (p1 >= 0);
                if (p0 >= 0) begin m_b0val = v0; m_b0tag = t0; m_b0src = 2'(p0); end
                if (p1 >= 0) begin m_b1val = v1; m_b1tag = t1; m_b1src = 2'(p1); end
                if (p1 >= 0) m_rr = (p1 + 1) % N;
                else if (p0 >= 0) m_rr = (p0 + 1) % N;
                if (up && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
    endtask

    task automatic set_unit(input int i, input logic [31:0] v, input logic [3:0] t);
        req_value[32*i +: 32] = v;
        req_tag[TW*i +: TW]   = t;
    endtask

    task automatic test_reset();
        rst_in = 0; rdy_in = 1; flush_in = 0; req_valid = 4'b1111;
        req_value = '0; req_tag = '0;
        model_zero();
        #2;
        n_total++;
        if (req_grant !== 4'b0) $display("FAIL reset_grant got %b want 0000", req_grant);
        else n_pass++;
        tick();
        n_total++;
        if ({bus0_valid, bus1_valid, bus0_value, bus0_tag, bus0_src, bus1_value, bus1_tag, bus1_src} !== '0)
            $display("FAIL reset_bus got v0=%b v1=%b val0=%h", bus0_valid, bus1_valid, bus0_value);
        else n_pass++;
        n_total++;
        if (conflict_cnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", conflict_cnt);
        else n_pass++;
        rst_in = 1; req_valid = 4'b0;
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        set_unit(2, 32'hDEAD_BEEF, 4'd5);
        #1;
        n_total++;
        if (req_grant !== 4'b0100) $display("FAIL single_grant got %b want 0100", req_grant);
        else n_pass++;
        tick();
        n_total++;
        if ({bus0_valid, bus0_tag, bus0_src, bus0_value} !== {1'b1, 4'd5, 2'd2, 32'hDEAD_BEEF})
            $display("FAIL single_bus0 got v=%b tag=%0d src=%0d val=%h want 1/5/2/deadbeef",
                     bus0_valid, bus0_tag, bus0_src, bus0_value);
        else n_pass++;
        n_total++;
        if (bus1_valid !== 1'b0) $display("FAIL single_bus1 got v=%b want 0", bus1_valid);
        else n_pass++;
    endtask

    task automatic test_wrap();
        req_valid = 4'b1001;
        set_unit(3, 32'h3333_0003, 4'd3);
        set_unit(0, 32'h0000_0A0A, 4'd10);
        #1;
        n_total++;
        if (req_grant !== 4'b1001) $display("FAIL wrap_grant got %b want 1001", req_grant);
        else n_pass++;
        tick();
        n_total++;
        if ({bus0_valid, bus0_src, bus0_tag, bus1_valid, bus1_src, bus1_tag} !==
            {1'b1, 2'd3, 4'd3, 1'b1, 2'd0, 4'd10})
            $display("FAIL wrap_src got src0=%0d src1=%0d v=%b%b want 3,0", bus0_src, bus1_src,
                     bus0_valid, bus1_valid);
        else n_pass++;
        // pointer now 1: unit 2 must outrank unit 0
        req_valid = 4'b0101;
        #1;
        tick();
        n_total++;
        if ({bus0_src, bus1_src} !== {2'd2, 2'd0})
            $display("FAIL wrap_ptr got src0=%0d src1=%0d want 2,0", bus0_src, bus1_src);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [15:0] c0;
        req_valid = 4'b0011;
        tick();
        n_total++;
        if ({bus0_valid, bus1_valid} !== 2'b11) $display("FAIL flush_pre got %b%b want 11", bus0_valid, bus1_valid);
        else n_pass++;
        c0 = conflict_cnt;
        flush_in = 1; req_valid = 4'b1111;
        #1;
        n_total++;
        if (req_grant !== 4'b0) $display("FAIL flush_grant got %b want 0000", req_grant);
        else n_pass++;
        tick();
        n_total++;
        if ({bus0_valid, bus1_valid} !== 2'b00) $display("FAIL flush_bus got %b%b want 00", bus0_valid, bus1_valid);
        else n_pass++;
        n_total++;
        if (conflict_cnt !== c0) $display("FAIL flush_cnt got %0d want %0d", conflict_cnt, c0);
        else n_pass++;
        flush_in = 0; req_valid = 4'b0;
    endtask

    task automatic test_all_four();
        logic [3:0] g_exp [3];
        logic [3:0] s_exp [3];
        logic [15:0] c0;
        g_exp[0] = 4'b0011; g_exp[1] = 4'b1100; g_exp[2] = 4'b0011;
        s_exp[0] = 4'b0001; s_exp[1] = 4'b1011; s_exp[2] = 4'b0001;
        for (int i = 0; i < N; i++) set_unit(i, 32'h1000_0000 + i, 4'(i + 8));
        req_valid = 4'b1111;
        c0 = conflict_cnt;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (req_grant !== g_exp[k]) $display("FAIL all4_grant%0d got %b want %b", k, req_grant, g_exp[k]);
            else n_pass++;
            tick();
            n_total++;
            if ({bus0_src, bus1_src} !== s_exp[k])
                $display("FAIL all4_src%0d got %0d,%0d want %0d,%0d", k, bus0_src, bus1_src,
                         s_exp[k][3:2], s_exp[k][1:0]);
            else n_pass++;
            n_total++;
            if (conflict_cnt !== c0 + 16'(k + 1))
                $display("FAIL all4_cnt%0d got %0d want %0d", k, conflict_cnt, c0 + 16'(k + 1));
            else n_pass++;
        end
        req_valid = 4'b0;
    endtask

    task automatic test_pause();
        req_valid = 4'b0001;
        set_unit(0, 32'h7777_7777, 4'd7);
        tick();
        rdy_in = 0; req_valid = 4'b0010;
        set_unit(1, 32'h1111_1111, 4'd1);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (req_grant !== 4'b0) $display("FAIL pause_grant%0d got %b want 0000", k, req_grant);
            else n_pass++;
            tick();
            n_total++;
            if ({bus0_valid, bus0_tag, bus0_value} !== {1'b1, 4'd7, 32'h7777_7777})
                $display("FAIL pause_hold%0d got v=%b tag=%0d want 1/7", k, bus0_valid, bus0_tag);
            else n_pass++;
        end
        rdy_in = 1;
        #1;
        n_total++;
        if (req_grant !== 4'b0010) $display("FAIL pause_resume got %b want 0010", req_grant);
        else n_pass++;
        tick();
        req_valid = 4'b0;
    endtask

    task automatic test_random();
        logic [3:0] g;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rdy_in   = ($urandom_range(0, 7) != 0);
            flush_in = ($urandom_range(0, 15) == 0);
            #1;
            g = exp_grant();
            n_total++;
            if (req_grant !== g) $display("FAIL rand_grant c%0d got %b want %b", cyc, req_grant, g);
            else n_pass++;
            tick();
            n_total++;
            if (bus_vec(bus0_valid, bus0_tag, bus0_src, bus0_value) !== bus_vec(m_b0v, m_b0tag, m_b0src, m_b0val))
                $display("FAIL rand_bus0 c%0d got v=%b src=%0d tag=%0d want v=%b src=%0d tag=%0d",
                         cyc, bus0_valid, bus0_src, bus0_tag, m_b0v, m_b0src, m_b0tag);
            else n_pass++;
            n_total++;
            if (bus_vec(bus1_valid, bus1_tag, bus1_src, bus1_value) !== bus_vec(m_b1v, m_b1tag, m_b1src, m_b1val))
                $display("FAIL rand_bus1 c%0d got v=%b src=%0d tag=%0d want v=%b src=%0d tag=%0d",
                         cyc, bus1_valid, bus1_src, bus1_tag, m_b1v, m_b1src, m_b1tag);
            else n_pass++;
            n_total++;
            if (conflict_cnt !== m_cnt) $display("FAIL rand_cnt c%0d got %0d want %0d", cyc, conflict_cnt, m_cnt);
            else n_pass++;
            // units hold until granted; a flush empties them
            for (int i = 0; i < N; i++) begin
                if (g[i] || !req_valid[i] || (flush_in && rdy_in)) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    set_unit(i, $urandom, 4'($urandom_range(0, 15)));
                end
            end
        end
        rdy_in = 1; flush_in = 0; req_valid = 4'b0;
    endtask

    task automatic test_async_reset();
        req_valid = 4'b0001;
        set_unit(0, 32'hCAFE_F00D, 4'd2);
        tick();
        n_total++;
        if (bus0_valid !== 1'b1) $display("FAIL areset_pre got v=%b want 1", bus0_valid);
        else n_pass++;
        req_valid = 4'b1111;
        #2;
        rst_in = 0;
        model_zero();
        #1;
        n_total++;
        if ({bus0_valid, conflict_cnt} !== 17'd0)
            $display("FAIL areset_clear got v=%b cnt=%0d want 0/0", bus0_valid, conflict_cnt);
        else n_pass++;
        n_total++;
        if (req_grant !== 4'b0) $display("FAIL areset_grant got %b want 0000", req_grant);
        else n_pass++;
        tick();
        n_total++;
        if ({req_grant, bus0_valid, bus1_valid} !== 6'd0)
            $display("FAIL areset_hold got g=%b v=%b%b want 0", req_grant, bus0_valid, bus1_valid);
        else n_pass++;
        rst_in = 1;
        #1;
        n_total++;
        if (req_grant !== 4'b0011) $display("FAIL areset_release got %b want 0011", req_grant);
        else n_pass++;
        tick();
        req_valid = 4'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_flush();
        test_all_four();
        test_pause();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
